// File: rtl/stream_oem_sorter.sv
// Frame-based streaming sorter: loads up to n keyed entries, sorts them in place with
// odd-even transposition passes over a register array, then streams them out in order.
module stream_oem_sorter #(
    parameter int WIDTH   = 3,
    parameter int n       = 16,
    parameter int PW      = 8,
    parameter int DESCEND = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_key,
    input  logic [PW-1:0]    in_payload,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_key,
    output logic [PW-1:0]    out_payload,
    output logic             out_last,
    output logic             busy
);
    localparam int CW = $clog2(n + 1);
    localparam int IW = $clog2(n);

    typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [CW-1:0]   rd_ptr;
    logic [IW-1:0]   phase;

    logic             pad      [n];
    logic [WIDTH-1:0] key      [n];
    logic [PW-1:0]    payload  [n];
    logic             pad_next [n];
    logic [WIDTH-1:0] key_next [n];
    logic [PW-1:0]    pay_next [n];
    logic [n-2:0]     swap;

    logic accept, xfer, done;
    logic [IW-1:0] rd_idx;

    assign in_ready  = (state == LOAD);
    assign busy      = (state != LOAD);
    assign out_valid = (state == DRAIN);
    assign accept    = in_valid & in_ready;
    assign xfer      = out_valid & out_ready;
    assign done      = xfer & out_last;
    assign rd_idx    = rd_ptr[IW-1:0];

    assign out_key     = out_valid ? key[rd_idx] : '0;
    assign out_payload = out_valid ? payload[rd_idx] : '0;
    assign out_last    = out_valid && (rd_ptr == count - CW'(1));

    // A pad slot orders after every real slot; real slots compare by key.
    generate
        for (genvar gi = 0; gi < n - 1; gi++) begin : g_cmp
            localparam logic PAR = logic'(gi % 2);
            logic after;
            assign after = (pad[gi] & ~pad[gi+1]) |
                           (~pad[gi] & ~pad[gi+1] &
                            ((DESCEND != 0) ? (key[gi] < key[gi+1]) : (key[gi] > key[gi+1])));
            assign swap[gi] = (state == SORT) && (phase[0] == PAR) && after;
        end
    endgenerate

    // Pairs in one phase are disjoint, so applying every active swap in order is safe.
    always_comb begin
        for (int j = 0; j < n; j++) begin
            pad_next[j] = pad[j];
            key_next[j] = key[j];
            pay_next[j] = payload[j];
        end
        for (int j = 0; j < n - 1; j++) begin
            if (swap[j]) begin
                pad_next[j]   = pad[j+1];
                key_next[j]   = key[j+1];
                pay_next[j]   = payload[j+1];
                pad_next[j+1] = pad[j];
                key_next[j+1] = key[j];
                pay_next[j+1] = payload[j];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < n; gi++) begin : g_slot
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pad[gi]     <= 1'b1;
                    key[gi]     <= '0;
                    payload[gi] <= '0;
                end else if (accept && (count == CW'(gi))) begin
                    pad[gi]     <= 1'b0;
                    key[gi]     <= in_key;
                    payload[gi] <= in_payload;
                end else if (done) begin
                    pad[gi]     <= 1'b1;
                end else begin
                    pad[gi]     <= pad_next[gi];
                    key[gi]     <= key_next[gi];
                    payload[gi] <= pay_next[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= LOAD;
            count  <= '0;
            phase  <= '0;
            rd_ptr <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        count <= count + CW'(1);
                        if (in_last || (count == CW'(n - 1))) begin
                            state <= SORT;
                            phase <= '0;
                        end
                    end
                end
                SORT: begin
                    if (phase == IW'(n - 1)) begin
                        state  <= DRAIN;
                        rd_ptr <= '0;
                    end else begin
                        phase <= phase + IW'(1);
                    end
                end
                DRAIN: begin
                    if (xfer) begin
                        rd_ptr <= rd_ptr + CW'(1);
                        if (out_last) begin
                            state <= LOAD;
                            count <= '0;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_stream_oem_sorter.sv
// Directed bench for stream_oem_sorter: ascending and descending instances, partial
// frames, capacity frames, output backpressure and asynchronous reset mid-frame.
module tb_stream_oem_sorter;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_last, out_ready;
    logic [2:0] in_key;
    logic [7:0] in_payload;
    logic       in_ready, out_valid, out_last, busy;
    logic [2:0] out_key;
    logic [7:0] out_payload;

    logic       d_in_valid, d_in_last, d_out_ready;
    logic [2:0] d_in_key;
    logic [7:0] d_in_payload;
    logic       d_in_ready, d_out_valid, d_out_last, d_busy;
    logic [2:0] d_out_key;
    logic [7:0] d_out_payload;

    int tests = 0;
    int fails = 0;
    int lat;
    logic [2:0] exp_key [16];
    logic [7:0] exp_pay [16];

    always #5 clk = ~clk;

    stream_oem_sorter u_asc (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key),
        .in_payload(in_payload), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_key(out_key),
        .out_payload(out_payload), .out_last(out_last), .busy(busy)
    );

    stream_oem_sorter #(.DESCEND(1)) u_desc (
        .clk(clk), .rst(rst),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_key(d_in_key),
        .in_payload(d_in_payload), .in_last(d_in_last),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_key(d_out_key),
        .out_payload(d_out_payload), .out_last(d_out_last), .busy(d_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one beat just after an edge; it is accepted on the next edge.
    task automatic send(input logic [2:0] k, input logic [7:0] p, input logic l);
        in_valid = 1'b1; in_key = k; in_payload = p; in_last = l;
        chk("in_ready_load", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
        chk("out_valid_wait", out_valid, 1);
    endtask

    task automatic drain(input int k, input bit bp);
        for (int i = 0; i < k; i++) begin
            if (bp && i > 0) begin
                out_ready = 1'b0;
                repeat (2) begin
                    @(posedge clk); #1;
                    chk("stall_key", out_key, exp_key[i]);
                    chk("stall_pay", out_payload, exp_pay[i]);
                    chk("stall_last", out_last, (i == k - 1));
                end
            end
            out_ready = 1'b1;
            chk("drain_valid", out_valid, 1);
            chk("drain_in_ready", in_ready, 0);
            chk("drain_key", out_key, exp_key[i]);
            chk("drain_pay", out_payload, exp_pay[i]);
            chk("drain_last", out_last, (i == k - 1));
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
        chk("post_drain_in_ready", in_ready, 1);
        chk("post_drain_valid", out_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; in_last = 0; in_key = 0; in_payload = 0; out_ready = 0;
        d_in_valid = 0; d_in_last = 0; d_in_key = 0; d_in_payload = 0; d_out_ready = 0;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_key", out_key, 0);
        chk("rst_out_pay", out_payload, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Test 1: full ascending frame, payload = arrival index
        begin
            logic [2:0] kin [8];
            logic [2:0] ek [16];
            logic [7:0] ep [16];
            kin = '{3'd7, 3'd0, 3'd5, 3'd3, 3'd6, 3'd1, 3'd4, 3'd2};
            ek  = '{0,0,1,1,2,2,3,3,4,4,5,5,6,6,7,7};
            ep  = '{1,9,5,13,7,15,3,11,6,14,2,10,4,12,0,8};
            for (int i = 0; i < 16; i++) send(kin[i % 8], 8'(i), (i == 15));
            exp_key = ek; exp_pay = ep;
            chk("t1_busy_sort", busy, 1);
            wait_valid(lat);
            chk("t1_latency", lat, 16);
            drain(16, 1'b0);
        end

        // Test 2: partial frame of 5
        begin
            logic [2:0] ek [16];
            logic [7:0] ep [16];
            ek = '{1,1,2,3,4,0,0,0,0,0,0,0,0,0,0,0};
            ep = '{11,13,14,12,10,0,0,0,0,0,0,0,0,0,0,0};
            send(3'd4, 8'd10, 0); send(3'd1, 8'd11, 0); send(3'd3, 8'd12, 0);
            send(3'd1, 8'd13, 0); send(3'd2, 8'd14, 1);
            chk("t2_in_ready_sort", in_ready, 0);
            exp_key = ek; exp_pay = ep;
            wait_valid(lat);
            chk("t2_latency", lat, 16);
            drain(5, 1'b0);
        end

        // Test 3: descending instance, 4 entries
        begin
            logic [2:0] kin [4];
            logic [2:0] ek [4];
            logic [7:0] ep [4];
            int c;
            kin = '{3'd2, 3'd7, 3'd0, 3'd5};
            ek  = '{7, 5, 2, 0};
            ep  = '{21, 23, 20, 22};
            for (int i = 0; i < 4; i++) begin
                d_in_valid = 1; d_in_key = kin[i]; d_in_payload = 8'(20 + i); d_in_last = (i == 3);
                chk("t3_in_ready", d_in_ready, 1);
                @(posedge clk); #1;
            end
            d_in_valid = 0; d_in_last = 0;
            c = 0;
            while (!d_out_valid && c < 100) begin @(posedge clk); #1; c++; end
            chk("t3_latency", c, 16);
            d_out_ready = 1;
            for (int i = 0; i < 4; i++) begin
                chk("t3_valid", d_out_valid, 1);
                chk("t3_key", d_out_key, ek[i]);
                chk("t3_pay", d_out_payload, ep[i]);
                chk("t3_last", d_out_last, (i == 3));
                @(posedge clk); #1;
            end
            d_out_ready = 0;
            chk("t3_no_pad_out", d_out_valid, 0);
            chk("t3_in_ready_after", d_in_ready, 1);
        end

        // Tests 5 and 4: capacity frame without in_last, drained under backpressure
        begin
            logic [2:0] ek [16];
            logic [7:0] ep [16];
            ek = '{0,0,1,1,2,2,3,3,4,4,5,5,6,6,7,7};
            ep = '{7,15,6,14,5,13,4,12,3,11,2,10,1,9,0,8};
            for (int i = 0; i < 16; i++) send(3'(7 - (i % 8)), 8'(i), 1'b0);
            chk("t5_in_ready_drop", in_ready, 0);
            chk("t5_busy", busy, 1);
            exp_key = ek; exp_pay = ep;
            wait_valid(lat);
            chk("t5_latency", lat, 16);
            drain(16, 1'b1);
        end

        // Test 6a: reset during SORT phase 5
        send(3'd1, 8'd1, 0); send(3'd2, 8'd2, 0); send(3'd3, 8'd3, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("t6_busy_before", busy, 1);
        rst = 1'b1; #2;
        chk("t6a_busy", busy, 0);
        chk("t6a_in_ready", in_ready, 1);
        chk("t6a_out_valid", out_valid, 0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        chk("t6a_in_ready_rel", in_ready, 1);

        // Test 6b: reset during drain beat 3
        send(3'd3, 8'd50, 0); send(3'd2, 8'd51, 0); send(3'd1, 8'd52, 0); send(3'd0, 8'd53, 1);
        wait_valid(lat);
        out_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        chk("t6b_beat3_key", out_key, 2);
        rst = 1'b1; #2;
        chk("t6b_out_valid", out_valid, 0);
        chk("t6b_out_key", out_key, 0);
        chk("t6b_out_pay", out_payload, 0);
        chk("t6b_out_last", out_last, 0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        chk("t6b_in_ready_rel", in_ready, 1);

        // Test 6c: clean frame after the aborts
        begin
            logic [2:0] ek [16];
            logic [7:0] ep [16];
            ek = '{1,6,6,0,0,0,0,0,0,0,0,0,0,0,0,0};
            ep = '{42,40,41,0,0,0,0,0,0,0,0,0,0,0,0,0};
            send(3'd6, 8'd40, 0); send(3'd6, 8'd41, 0); send(3'd1, 8'd42, 1);
            exp_key = ek; exp_pay = ep;
            wait_valid(lat);
            chk("t6c_latency", lat, 16);
            drain(3, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/stream_oem_sorter.md
Name: stream_oem_sorter

Overview:
- Frame-based streaming sorter for the V2V sorter module.
- Accepts a frame of up to n keyed entries serially (key plus payload, e.g. vehicle ID), sorts them in place with odd-even transposition compare-exchange passes over a register array, then streams them out in order.
- Generalises the fixed combinational merge networks:
  - parametrised depth, key width and payload width;
  - selectable sort direction;
  - partial frames;
  - valid/ready backpressure on both sides.

Parameters:
- WIDTH, 3, key width in bits.
- n, 16, maximum entries per frame (even, >=2).
- PW, 8, payload width in bits, carried with its key.
- DESCEND, 0, 0 = ascending keys out, 1 = descending.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  sorter accepts a beat this cycle.
- in_key  input  WIDTH  entry key.
- in_payload  input  PW  entry payload.
- in_last  input  1  final beat of frame.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts beat.
- out_key  output  WIDTH  sorted key.
- out_payload  output  PW  payload of out_key.
- out_last  output  1  final output beat of frame.
- busy  output  1  high in SORT or DRAIN.

Behaviour:
- Reset (async, rst=1):
  - state=LOAD; count=0; phase=0; rd_ptr=0.
  - All array slots marked pad.
  - in_ready=1 after reset released; out_valid=0, out_key=0, out_payload=0, out_last=0, busy=0.
- Storage:
  - n slots, each {pad flag, key, payload}.
  - A pad slot always orders after every real slot regardless of DESCEND.
- LOAD:
  - in_ready=1.
  - A beat is accepted when in_valid&in_ready; it is written to slot[count] with pad=0, then count++.
  - Frame ends on an accepted beat with in_last=1, or on the nth accepted beat (in_last ignored there); next state is SORT, phase=0.
  - in_valid=0 in LOAD holds state.
- SORT:
  - in_ready=0, busy=1; lasts exactly n cycles.
  - Cycle p compares pairs (2i, 2i+1) when p is even, (2i+1, 2i+2) when p is odd.
  - Swap only when the left slot strictly orders after the right:
    - pad after real;
    - key greater for ascending, key less for descending.
  - Equal keys never swap, so the sort is stable (arrival order kept).
  - After phase n-1 the next state is DRAIN, rd_ptr=0.
- DRAIN:
  - out_valid=1 and out_key/out_payload=slot[rd_ptr], driven combinationally from the registered array and rd_ptr.
  - out_last=1 when rd_ptr==count-1.
  - On out_valid&out_ready: rd_ptr++.
  - out_ready=0 holds all outputs stable.
  - Transfer with out_last next state is LOAD: count=0, all slots re-marked pad, in_ready=1 in the following cycle.
  - Outside DRAIN, out_valid=0 and out_key/out_payload/out_last=0.
- Latency: frame of k entries gives k load beats, then n sort cycles, then k drain beats. The first out_valid appears n cycles after the cycle the last beat is accepted.
- Boundaries:
  - Empty frames are impossible: in_last is only sampled on an accepted beat, so k>=1.
  - k=1: sort passes are harmless; a single beat is output with out_last=1.
  - Pad slots never reach the output.
  - No overlap: the next frame is not accepted until the drain completes. Upstream stalls via in_ready=0.
  - rst asserted mid-frame (any state) aborts immediately with all reset values; partial data is discarded and no out_last is issued.
  - Width: all compares are unsigned on WIDTH bits. count and rd_ptr are $clog2(n+1) bits; count never exceeds n.

Test Plan:
1. Full frame, ascending, defaults: keys 7,0,5,3,6,1,4,2,7,0,5,3,6,1,4,2 with payloads 0..15 -> out keys 0,0,1,1,...,7,7. Payload order within each tie is ascending, e.g. key 0 -> payloads 1,9. out_last only on beat 16. First out_valid is 16 cycles after the last in beat.
2. Partial frame: 5 beats keys 4,1,3,1,2, in_last on beat 5 -> exactly 5 outputs 1,1,2,3,4 with out_last on the 5th; in_ready=0 until that transfer, then 1 the next cycle.
3. DESCEND=1: keys 2,7,0,5 with in_last -> out 7,5,2,0; pad slots never emitted.
4. Backpressure: during drain toggle out_ready 1,0,0,1,... -> out_key/out_payload/out_last are stable while stalled; no beat is lost or duplicated.
5. in_last ignored at capacity: 16 beats with in_last=0 -> SORT entered after beat 16, and in_ready drops the next cycle.
6. Reset mid-operation: assert rst during SORT phase 5 and during drain beat 3 -> outputs are zero immediately (async) and in_ready=1 after release. A following 3-beat frame 6,6,1 outputs 1,6,6 with correct payloads, proving no stale data survives.
